// File: rtl/xalu_pkg.sv
// Shared definitions for the XALU multiply/divide unit.
// Contents: operation encoding, top-level FSM state, divider phase,
// divider latency constant and a magnitude helper.
package xalu_pkg;

  // Operation encoding presented on the op port.
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_t;

  // Top-level sequencer state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  // Divider phase: idle, 32 shift/subtract iterations, one sign-fixup cycle.
  typedef enum logic [1:0] {
    DV_IDLE = 2'd0,
    DV_RUN  = 2'd1,
    DV_FIX  = 2'd2
  } div_phase_t;

  // Fixed by the radix-2 divider: 32 iterations plus the fixup cycle.
  localparam int DIV_CYCLES = 33;

  // Magnitude of v when treated as signed (sgn=1); v itself otherwise.
  // 32'h80000000 maps to itself, which is its correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/xalu_divider.sv
// 32-bit iterative restoring divider, signed or unsigned.
// Divides operand magnitudes one quotient bit per cycle for 32 cycles, then
// spends one cycle with sign-corrected results presented on its outputs.
// Ports:
//   clk, resetn          clock, async active-low reset
//   start                one-cycle launch pulse (sampled only in DV_IDLE)
//   is_signed            1: DIV semantics, 0: DIVU semantics
//   dividend, divisor    operands, captured on the start edge
//   done                 high during the fixup cycle; results valid then
//   quotient, remainder  sign-corrected results (divide-by-zero handled here)
//   phase                current divider phase, for observation
//
// Handshake: start is a single-cycle request accepted only while phase is
// DV_IDLE (no ready signal; the caller must not start while busy). done is
// high for exactly one cycle, 33 cycles after the start edge, and quotient/
// remainder are valid only while done is high.
module xalu_divider
  import xalu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output div_phase_t  phase
);

  div_phase_t  phase_q, phase_d;
  logic [4:0]  iter;
  logic [31:0] rem;        // partial remainder (always < dvs)
  logic [31:0] quo;        // dividend bits shift out, quotient bits shift in
  logic [31:0] dvs;        // divisor magnitude
  logic [31:0] dividend_q; // raw dividend, returned as HI on divide-by-zero
  logic        neg_q;
  logic        neg_r;
  logic        div_zero;

  logic [32:0] partial;
  logic [32:0] trial;
  logic        q_bit;

  // One restoring step: bring down the next dividend bit, try a subtract.
  always_comb begin
    partial = {rem, quo[31]};
    trial   = partial - {1'b0, dvs};
    q_bit   = ~trial[32];
  end

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      DV_IDLE: if (start) phase_d = DV_RUN;
      DV_RUN:  if (iter == 5'd0) phase_d = DV_FIX;
      DV_FIX:  phase_d = DV_IDLE;
      default: phase_d = DV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) phase_q <= DV_IDLE;
    else         phase_q <= phase_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iter       <= 5'd0;
      rem        <= 32'd0;
      quo        <= 32'd0;
      dvs        <= 32'd0;
      dividend_q <= 32'd0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      if (phase_q == DV_IDLE && start) begin
        iter       <= 5'd31;
        rem        <= 32'd0;
        quo        <= mag32(dividend, is_signed);
        dvs        <= mag32(divisor, is_signed);
        dividend_q <= dividend;
        // Quotient negative when signs differ; remainder follows the dividend.
        neg_q      <= is_signed && (dividend[31] ^ divisor[31]);
        neg_r      <= is_signed && dividend[31];
        div_zero   <= (divisor == 32'd0);
      end else if (phase_q == DV_RUN) begin
        rem  <= q_bit ? trial[31:0] : partial[31:0];
        quo  <= {quo[30:0], q_bit};
        iter <= iter - 5'd1;
      end
    end
  end

  // Sign fixup is applied on the outputs; the fixup cycle is when they are used.
  always_comb begin
    done      = (phase_q == DV_FIX);
    quotient  = div_zero ? 32'hFFFF_FFFF : (neg_q ? (~quo + 32'd1) : quo);
    remainder = div_zero ? dividend_q    : (neg_r ? (~rem + 32'd1) : rem);
    phase     = phase_q;
  end

endmodule

// File: rtl/xalu_muldiv.sv
// XALU multi-cycle multiply/divide unit owning the HI/LO registers.
// One operation per start pulse; busy stays high until HI/LO are written.
// Ports:
//   clk, resetn     clock, async active-low reset
//   start, op       launch request and operation code (xalu_pkg::op_t)
//   src_a, src_b    rs / rt operands
//   flush           kills a start in the same cycle; no effect on an op in flight
//   busy            operation in flight, HI/LO not yet valid
//   hi, lo          architectural HI/LO registers
//   state           sequencer state, for observation
//   div_phase       divider phase, for observation
//
// Handshake: start is accepted only when state is ST_IDLE and flush is low.
// busy is the registered "not ready" indication: it rises on the accepting
// edge and falls on the edge that writes HI/LO. A start may be issued in the
// first cycle busy is low; a start while busy is high is a protocol error.
module xalu_muldiv
  import xalu_pkg::*;
#(
  parameter int MULT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output state_t      state,
  output div_phase_t  div_phase
);

  state_t      state_q, state_d;
  logic [7:0]  counter;
  logic [31:0] a_q, b_q;
  logic        mul_signed;
  logic [63:0] product;

  logic        accept;
  logic        is_mul_op;
  logic        is_div_op;

  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;

  always_comb begin
    accept    = start && !flush && (state_q == ST_IDLE);
    is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
    is_div_op = (op == OP_DIV)  || (op == OP_DIVU);
  end

  // Sign-extending only for MULT lets one 64-bit multiply serve both forms.
  always_comb begin
    product = {{32{mul_signed & a_q[31]}}, a_q} * {{32{mul_signed & b_q[31]}}, b_q};
  end

  xalu_divider u_divider (
    .clk       (clk),
    .resetn    (resetn),
    .start     (accept && is_div_op),
    .is_signed (op == OP_DIV),
    .dividend  (src_a),
    .divisor   (src_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem),
    .phase     (div_phase)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_mul_op)      state_d = ST_MUL;
        else if (accept && is_div_op) state_d = ST_DIV;
      end
      ST_MUL:  if (counter == 8'd0) state_d = ST_IDLE;
      // The divider's done coincides with counter reaching zero.
      ST_DIV:  if (div_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      counter    <= 8'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      mul_signed <= 1'b0;
      hi         <= 32'd0;
      lo         <= 32'd0;
    end else begin
      if (state_q == ST_IDLE) begin
        if (accept && is_mul_op) begin
          counter    <= 8'(MULT_CYCLES - 1);
          a_q        <= src_a;
          b_q        <= src_b;
          mul_signed <= (op == OP_MULT);
        end else if (accept && is_div_op) begin
          counter <= 8'(DIV_CYCLES - 1);
        end
        if (accept && op == OP_MTHI) hi <= src_a;
        if (accept && op == OP_MTLO) lo <= src_a;
      end else if (counter != 8'd0) begin
        counter <= counter - 8'd1;
      end

      if (state_q == ST_MUL && counter == 8'd0) begin
        hi <= product[63:32];
        lo <= product[31:0];
      end
      if (state_q == ST_DIV && div_done) begin
        hi <= div_rem;
        lo <= div_quo;
      end
    end
  end

  always_comb begin
    busy  = (state_q != ST_IDLE);
    state = state_q;
  end

  // The decode-stage stall must keep new starts away while an op is in flight.
  assert property (@(posedge clk) disable iff (!resetn) !(start && busy));

endmodule
